pc_unit: RTL

- Parametrised successor to the single-register program counter.
- Adds next-PC selection (sequential, branch, jump, call, return, exception), a configurable reset/exception vector, and a circular return-address stack (RAS) with overflow/underflow status.
- Sits at the head of the IF stage and drives the instruction-memory address. Redirect requests come from the ID/EX hazard and branch logic.

---
 rtl/pc_unit_if.sv | 38 +++
 rtl/pc_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-side request/status bundle for pc_unit.
// Carries the run/stall gating, redirect requests and the PC/RAS status outputs.
interface pc_unit_if #(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned RAS_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic            start_i;
   logic            stall_i;
   logic            pc_enable_i;
   logic            branch_i;
   logic [PC_W-1:0] branch_target_i;
   logic            jump_i;
   logic            call_i;
   logic [PC_W-1:0] jump_target_i;
   logic            ret_i;
   logic            exc_i;
   logic [PC_W-1:0] pc_o;
   logic            pc_valid_o;
   logic [CNT_W-1:0] ras_count_o;
   logic            ras_overflow_o;
   logic            ras_underflow_o;

   // Requester side: hazard/branch logic and the fetch consumer.
   modport master (
      output start_i, stall_i, pc_enable_i, branch_i, branch_target_i,
             jump_i, call_i, jump_target_i, ret_i, exc_i,
      input  pc_o, pc_valid_o, ras_count_o, ras_overflow_o, ras_underflow_o
   );

   // PC unit side.
   modport slave (
      input  start_i, stall_i, pc_enable_i, branch_i, branch_target_i,
             jump_i, call_i, jump_target_i, ret_i, exc_i,
      output pc_o, pc_valid_o, ras_count_o, ras_overflow_o, ras_underflow_o
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC selection, exception vector and a
// circular return-address stack with sticky overflow/underflow status.
module pc_unit #(
   parameter int unsigned    PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080),
   parameter int unsigned    STEP      = 4,
   parameter int unsigned    RAS_DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   pc_unit_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PC_W-1:0]  STEP_V = PC_W'(STEP);
   localparam logic [CNT_W-1:0] FULL_V = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  r_pc;
   logic             r_valid;
   logic [CNT_W-1:0] r_cnt;
   logic [PTR_W-1:0] r_ptr;
   logic             r_ovf;
   logic             r_unf;
   logic [PC_W-1:0]  r_ras [RAS_DEPTH];

   logic             w_exc;
   logic             w_adv;
   logic             w_push;
   logic             w_empty;
   logic [PC_W-1:0]  w_pc_seq;
   logic [PTR_W-1:0] w_ptr_top;

   always_comb begin
      w_exc     = bus.start_i & bus.exc_i;
      w_adv     = bus.start_i & bus.pc_enable_i & ~bus.stall_i;
      w_push    = w_adv & ~w_exc & ~bus.ret_i & bus.call_i;
      w_empty   = (r_cnt == '0);
      w_pc_seq  = r_pc + STEP_V;
      w_ptr_top = r_ptr - PTR_W'(1);
   end

   // PC, pointer, count and status; exception outranks every other request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pc    <= RESET_VEC;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (w_exc) begin
         r_pc    <= EXC_VEC;
         r_valid <= 1'b1;
      end else if (w_adv) begin
         r_valid <= 1'b1;
         if (bus.ret_i) begin
            if (!w_empty) begin
               r_pc  <= r_ras[w_ptr_top];
               r_ptr <= w_ptr_top;
               r_cnt <= r_cnt - CNT_W'(1);
            end else begin
               r_pc  <= bus.jump_target_i;
               r_unf <= 1'b1;
            end
         end else if (bus.call_i) begin
            r_pc  <= bus.jump_target_i;
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_cnt != FULL_V) r_cnt <= r_cnt + CNT_W'(1);
            else                 r_ovf <= 1'b1;
         end else if (bus.jump_i) begin
            r_pc <= bus.jump_target_i;
         end else if (bus.branch_i) begin
            r_pc <= bus.branch_target_i;
         end else begin
            r_pc <= w_pc_seq;
         end
      end
   end

   // Stack storage carries no reset; a full push overwrites the oldest slot.
   always_ff @(posedge clk_i) begin
      if (w_push) r_ras[r_ptr] <= w_pc_seq;
   end

   assign bus.pc_o            = r_pc;
   assign bus.pc_valid_o      = r_valid;
   assign bus.ras_count_o     = r_cnt;
   assign bus.ras_overflow_o  = r_ovf;
   assign bus.ras_underflow_o = r_unf;
endmodule
